// File: rtl/gate_timing_monitor.sv
// -----------------------------------------------------------------------------
// gate_timing_monitor
//
// Measures the switching pattern of a complementary gate-drive pair. One
// measurement spans c1 rise to the next c1 rise and yields the c1-high time,
// the dead time after c1 falls, the c2-high time, the dead time after c2 falls
// and the total period. All fields saturate instead of wrapping. Illegal
// orderings and shoot-through (both gates high) are flagged.
//
// Ports
//   i_clk      : clock, all logic on the rising edge
//   reset      : synchronous, active-low reset
//   enable     : 1 = measurement runs, 0 = forced idle (fault still tracked)
//   i_c1, i_c2 : high-side / low-side gate signals, already synchronous
//   i_clr      : clears the sticky shoot-through flag
//   o_ton      : c1-high cycles of the last complete period
//   o_dt1      : both-low cycles from c1 fall to c2 rise
//   o_toff     : c2-high cycles
//   o_dt2      : both-low cycles from c2 fall to c1 rise
//   o_period   : cycles from one c1 rise to the next
//   o_valid    : one-cycle strobe when the fields above are refreshed
//   o_sat      : some field of the refreshed measurement saturated
//   o_seq_err  : one-cycle strobe on an illegal gate ordering
//   o_fault    : sticky shoot-through flag
// -----------------------------------------------------------------------------
module gate_timing_monitor #(
    parameter int CNT_W = 11,
    parameter int DT_W  = 8
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             i_c1,
    input  logic             i_c2,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_ton,
    output logic [DT_W-1:0]  o_dt1,
    output logic [CNT_W-1:0] o_toff,
    output logic [DT_W-1:0]  o_dt2,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_sat,
    output logic             o_seq_err,
    output logic             o_fault
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TON  = 3'd1,
        DT1  = 3'd2,
        TOFF = 3'd3,
        DT2  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [DT_W-1:0]  DT_ONE   = DT_W'(1);
    localparam logic [DT_W-1:0]  DT_ZERO  = DT_W'(0);

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [DT_W-1:0] dt_sat_inc(input logic [DT_W-1:0] v);
        return (&v) ? v : v + DT_ONE;
    endfunction

    state_t           state_r, state_next_s;
    logic             r_c1, r_c2;
    logic             c1_prev_r, in_live_r;
    logic [CNT_W-1:0] ton_cnt_r, toff_cnt_r, period_cnt_r;
    logic [DT_W-1:0]  dt1_cnt_r, dt2_cnt_r;
    logic             sat_r;

    logic [1:0]       gates_s;
    logic             overlap_s, c1_rise_s;
    logic             start_s, latch_s, seq_err_s;
    logic             ton_inc_s, dt1_inc_s, toff_inc_s, dt2_inc_s, period_inc_s;
    logic             sat_hit_s;

    assign gates_s   = {r_c1, r_c2};
    assign overlap_s = r_c1 & r_c2;
    assign c1_rise_s = r_c1 & ~c1_prev_r & ~r_c2;
    // The period counter runs in every measuring state; a restart overrides it.
    assign period_inc_s = (state_r != IDLE);
    assign sat_hit_s = (ton_inc_s    & (&ton_cnt_r))  |
                       (dt1_inc_s    & (&dt1_cnt_r))  |
                       (toff_inc_s   & (&toff_cnt_r)) |
                       (dt2_inc_s    & (&dt2_cnt_r))  |
                       (period_inc_s & (&period_cnt_r));

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle control decode; shoot-through beats sequencing
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        latch_s      = 1'b0;
        seq_err_s    = 1'b0;
        ton_inc_s    = 1'b0;
        dt1_inc_s    = 1'b0;
        toff_inc_s   = 1'b0;
        dt2_inc_s    = 1'b0;
        if (overlap_s || !enable) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (c1_rise_s) begin
                        state_next_s = TON;
                        start_s      = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                TON: begin
                    case (gates_s)
                        2'b10:   ton_inc_s = 1'b1;
                        2'b00:   state_next_s = DT1;
                        2'b01: begin
                            seq_err_s    = 1'b1;
                            state_next_s = IDLE;
                        end
                        default: state_next_s = IDLE;
                    endcase
                end
                DT1: begin
                    case (gates_s)
                        2'b00:   dt1_inc_s = 1'b1;
                        2'b01:   state_next_s = TOFF;
                        2'b10: begin
                            seq_err_s    = 1'b1;
                            start_s      = 1'b1;
                            state_next_s = TON;
                        end
                        default: state_next_s = IDLE;
                    endcase
                end
                TOFF: begin
                    case (gates_s)
                        2'b01:   toff_inc_s = 1'b1;
                        2'b00:   state_next_s = DT2;
                        2'b10: begin
                            seq_err_s    = 1'b1;
                            start_s      = 1'b1;
                            state_next_s = TON;
                        end
                        default: state_next_s = IDLE;
                    endcase
                end
                DT2: begin
                    case (gates_s)
                        2'b00:   dt2_inc_s = 1'b1;
                        2'b10: begin
                            latch_s      = 1'b1;
                            start_s      = 1'b1;
                            state_next_s = TON;
                        end
                        2'b01: begin
                            seq_err_s    = 1'b1;
                            state_next_s = IDLE;
                        end
                        default: state_next_s = IDLE;
                    endcase
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Gate input registers, phase counters, saturation tracking and output latches
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            r_c1         <= 1'b0;
            r_c2         <= 1'b0;
            // Held high so a c1 level already high at release is not taken as a rise.
            c1_prev_r    <= 1'b1;
            in_live_r    <= 1'b0;
            ton_cnt_r    <= CNT_ZERO;
            dt1_cnt_r    <= DT_ZERO;
            toff_cnt_r   <= CNT_ZERO;
            dt2_cnt_r    <= DT_ZERO;
            period_cnt_r <= CNT_ZERO;
            sat_r        <= 1'b0;
            o_ton        <= CNT_ZERO;
            o_dt1        <= DT_ZERO;
            o_toff       <= CNT_ZERO;
            o_dt2        <= DT_ZERO;
            o_period     <= CNT_ZERO;
            o_valid      <= 1'b0;
            o_sat        <= 1'b0;
            o_seq_err    <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            r_c1      <= i_c1;
            r_c2      <= i_c2;
            in_live_r <= 1'b1;
            // r_c1 holds its reset value for one cycle after release; do not trust it.
            c1_prev_r <= in_live_r ? r_c1 : 1'b1;
            o_valid   <= latch_s;
            o_seq_err <= seq_err_s;

            if (overlap_s) begin
                o_fault <= 1'b1;
            end else if (i_clr) begin
                o_fault <= 1'b0;
            end else begin
                o_fault <= o_fault;
            end

            if (latch_s) begin
                o_ton    <= ton_cnt_r;
                o_dt1    <= dt1_cnt_r;
                o_toff   <= toff_cnt_r;
                o_dt2    <= dt2_cnt_r;
                o_period <= period_cnt_r;
                o_sat    <= sat_r;
            end

            // Each phase counter is preloaded with 1 at period start: the cycle
            // that triggers a phase change is the first cycle of the new phase.
            if (start_s) begin
                ton_cnt_r    <= CNT_ONE;
                dt1_cnt_r    <= DT_ONE;
                toff_cnt_r   <= CNT_ONE;
                dt2_cnt_r    <= DT_ONE;
                period_cnt_r <= CNT_ONE;
                sat_r        <= 1'b0;
            end else begin
                if (ton_inc_s)    ton_cnt_r    <= cnt_sat_inc(ton_cnt_r);
                if (dt1_inc_s)    dt1_cnt_r    <= dt_sat_inc(dt1_cnt_r);
                if (toff_inc_s)   toff_cnt_r   <= cnt_sat_inc(toff_cnt_r);
                if (dt2_inc_s)    dt2_cnt_r    <= dt_sat_inc(dt2_cnt_r);
                if (period_inc_s) period_cnt_r <= cnt_sat_inc(period_cnt_r);
                if (sat_hit_s)    sat_r        <= 1'b1;
            end
        end
    end

endmodule
